// File: rtl/mem_pkg.sv
// Purpose: shared types and sizing helpers for the data-RAM responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_READ,
        CMD_WRITE,
        CMD_ERR
    } cmd_t;

    // Wait-state counter width. It never drops below one bit, so the
    // register stays legal when WAIT_STATES is 0.
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

    localparam int DEFAULT_WAIT_STATES = 2;
    localparam int DEFAULT_CNT_W       = cnt_width(DEFAULT_WAIT_STATES);

endpackage

// File: rtl/sp_ram.sv
// Purpose: single-port byte storage with a synchronous write and a registered read.
// Latency: a write or read takes effect on the edge where its enable is high.
// Backpressure: none; the port accepts one access per cycle.
// Ports: i_we/i_re are the enables, i_addr/i_wdata are the access operands,
//        o_rdata is the read register (reset to 0; array contents are not reset).
module sp_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);

    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // A write that coincides with reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_we && !i_rst) begin
            mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= 8'h00;
        end else if (i_re) begin
            o_rdata <= mem[i_addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Purpose: responder for the core's 8-bit data-RAM strobe handshake, with programmable wait states.
// Latency: a strobe in cycle N gives o_done in cycle N+1+WAIT_STATES; the next strobe is accepted from N+2+WAIT_STATES.
// Backpressure: none; a strobe that arrives while busy is dropped and sets the sticky o_overrun.
// Ports: i_read/i_write strobes carry i_addr/i_wdata for one cycle; o_done pulses once per
//        accepted request, o_err marks a read+write strobe, o_rdata holds the last read result.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_read,
    input  logic        i_write,
    output logic [7:0]  o_rdata,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_overrun
);

    localparam int                CNT_W    = cnt_width(WAIT_STATES);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                  state, state_nxt;
    cmd_t                    cmd_q, cmd_in, commit_cmd;
    logic [ADDR_WIDTH-1:0]   addr_q, ram_addr;
    logic [7:0]              wdata_q, ram_wdata;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    strobe, commit;
    logic                    ram_we, ram_re;

    // Upper address bits only alias onto the array; they are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, i_addr};

    assign strobe = i_read | i_write;
    assign cmd_in = (i_read && i_write) ? CMD_ERR :
                    (i_read             ? CMD_READ : CMD_WRITE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        commit     = 1'b0;
        commit_cmd = cmd_q;
        ram_addr   = addr_q;
        ram_wdata  = wdata_q;
        case (state)
            S_IDLE: begin
                if (strobe) begin
                    if (WAIT_STATES == 0) begin
                        // No wait states: commit straight from the strobe inputs.
                        commit     = 1'b1;
                        commit_cmd = cmd_in;
                        ram_addr   = i_addr[ADDR_WIDTH-1:0];
                        ram_wdata  = i_wdata;
                        state_nxt  = S_DONE;
                    end else begin
                        cnt_nxt   = CNT_INIT;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Malformed requests commit with neither enable, so storage and o_rdata stay put.
    assign ram_we = commit && (commit_cmd == CMD_WRITE);
    assign ram_re = commit && (commit_cmd == CMD_READ);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cmd_q     <= CMD_READ;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            o_done <= (state_nxt == S_DONE);
            o_busy <= (state_nxt != S_IDLE);
            o_err  <= (state_nxt == S_DONE) && (commit_cmd == CMD_ERR);
            if (state == S_IDLE && strobe) begin
                cmd_q   <= cmd_in;
                addr_q  <= i_addr[ADDR_WIDTH-1:0];
                wdata_q <= i_wdata;
            end
            if (state != S_IDLE && strobe) begin
                o_overrun <= 1'b1;
            end
        end
    end

    sp_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (ram_we),
        .i_re   (ram_re),
        .i_addr (ram_addr),
        .i_wdata(ram_wdata),
        .o_rdata(o_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: self-checking bench driving three responders (0, 2 and 3 wait states) against a byte-array model.
// Latency: each request is expected to complete WAIT_STATES+1 cycles after its strobe.
// Backpressure: requests are spaced at the minimum WAIT_STATES+2 cycles, except where overrun is provoked.
module tb_data_mem_responder;

    localparam int NDUT = 3;
    localparam int WS [NDUT] = '{2, 0, 3};

    logic        clk;
    logic        rst   [NDUT];
    logic [15:0] addr  [NDUT];
    logic [7:0]  wdata [NDUT];
    logic        rd    [NDUT];
    logic        wr    [NDUT];
    logic [7:0]  rdata [NDUT];
    logic        done  [NDUT];
    logic        busy  [NDUT];
    logic        err   [NDUT];
    logic        ovr   [NDUT];

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
        .i_clk(clk), .i_rst(rst[0]), .i_addr(addr[0]), .i_wdata(wdata[0]),
        .i_read(rd[0]), .i_write(wr[0]), .o_rdata(rdata[0]), .o_done(done[0]),
        .o_busy(busy[0]), .o_err(err[0]), .o_overrun(ovr[0]));

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .i_clk(clk), .i_rst(rst[1]), .i_addr(addr[1]), .i_wdata(wdata[1]),
        .i_read(rd[1]), .i_write(wr[1]), .o_rdata(rdata[1]), .o_done(done[1]),
        .o_busy(busy[1]), .o_err(err[1]), .o_overrun(ovr[1]));

    data_mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
        .i_clk(clk), .i_rst(rst[2]), .i_addr(addr[2]), .i_wdata(wdata[2]),
        .i_read(rd[2]), .i_write(wr[2]), .o_rdata(rdata[2]), .o_done(done[2]),
        .o_busy(busy[2]), .o_err(err[2]), .o_overrun(ovr[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: a 256-byte array per responder plus the last value read out.
    logic [7:0] mdl_mem   [NDUT][256];
    logic [7:0] mdl_rdata [NDUT];

    typedef struct {
        int          d;
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [7:0]  wd;
        logic        exp_e;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_apply(input int d, input logic r, input logic w, input logic [15:0] a,
                               input logic [7:0] wd, output logic exp_e, output logic [7:0] exp_rd);
        int idx;
        idx   = int'(a) % 256;
        exp_e = r && w;
        if (!(r && w)) begin
            if (w) mdl_mem[d][idx] = wd;
            else   mdl_rdata[d]    = mdl_mem[d][idx];
        end
        exp_rd = mdl_rdata[d];
    endtask

    // Issue one strobe, check busy/done timing, return err and rdata seen in the done cycle.
    // Returns one cycle after done, which is the earliest legal next strobe.
    task automatic do_req(input int d, input logic r, input logic w, input logic [15:0] a,
                          input logic [7:0] wd, output logic e, output logic [7:0] rdo);
        logic [15:0] junk;
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
        e = 1'b0; rdo = 8'h00;
        for (int i = 1; i <= WS[d] + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                junk     = 16'($urandom);
                rd[d]    = 1'b0;
                wr[d]    = 1'b0;
                addr[d]  = junk;
                wdata[d] = junk[7:0];
            end
            check("busy_during", busy[d], 1);
            check("done_timing", done[d], (i == WS[d] + 1));
            if (i == WS[d] + 1) begin
                e   = err[d];
                rdo = rdata[d];
            end else begin
                check("err_early", err[d], 0);
            end
        end
        @(negedge clk);
        check("done_after", done[d], 0);
        check("busy_after", busy[d], 0);
        check("err_after", err[d], 0);
    endtask

    task automatic model_req(input int d, input logic r, input logic w, input logic [15:0] a,
                             input logic [7:0] wd);
        logic       e, ee;
        logic [7:0] ro, er;
        model_apply(d, r, w, a, wd, ee, er);
        do_req(d, r, w, a, wd, e, ro);
        check("err", e, ee);
        check("rdata", ro, er);
    endtask

    initial begin
        logic        e, ee;
        logic [7:0]  ro, er;
        logic [15:0] ra;
        int          ndone;
        int          sel;

        tbl[0]  = '{0, 1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0, 8'h00};
        tbl[1]  = '{0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 8'hA5};
        tbl[2]  = '{0, 1'b0, 1'b1, 16'h0020, 8'h5A, 1'b0, 8'hA5};
        tbl[3]  = '{0, 1'b1, 1'b1, 16'h0020, 8'hFF, 1'b1, 8'hA5};
        tbl[4]  = '{0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 8'h5A};
        tbl[5]  = '{0, 1'b0, 1'b1, 16'hFFFF, 8'h11, 1'b0, 8'h5A};
        tbl[6]  = '{0, 1'b0, 1'b1, 16'hFFFE, 8'h22, 1'b0, 8'h5A};
        tbl[7]  = '{0, 1'b1, 1'b0, 16'hFFFE, 8'h00, 1'b0, 8'h22};
        tbl[8]  = '{0, 1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h11};
        tbl[9]  = '{1, 1'b0, 1'b1, 16'hFFFF, 8'h3C, 1'b0, 8'h00};
        tbl[10] = '{1, 1'b1, 1'b0, 16'h00FF, 8'h00, 1'b0, 8'h3C};
        tbl[11] = '{1, 1'b0, 1'b1, 16'h0020, 8'h66, 1'b0, 8'h3C};
        tbl[12] = '{1, 1'b1, 1'b1, 16'h0020, 8'h99, 1'b1, 8'h3C};
        tbl[13] = '{1, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 8'h66};

        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = 16'h0000; wdata[d] = 8'h00;
            mdl_rdata[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_rdata", rdata[d], 8'h00);
            check("reset_done", done[d], 0);
            check("reset_busy", busy[d], 0);
            check("reset_err", err[d], 0);
            check("reset_overrun", ovr[d], 0);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        // Directed vectors: basic write/read, malformed strobe, aliasing, stack LIFO.
        for (int t = 0; t < 14; t++) begin
            do_req(tbl[t].d, tbl[t].r, tbl[t].w, tbl[t].a, tbl[t].wd, e, ro);
            check("tbl_err", e, tbl[t].exp_e);
            check("tbl_rdata", ro, tbl[t].exp_rd);
            model_apply(tbl[t].d, tbl[t].r, tbl[t].w, tbl[t].a, tbl[t].wd, ee, er);
        end

        // Overrun: second read two cycles after the first on the 3-wait-state unit.
        model_req(2, 1'b0, 1'b1, 16'h0040, 8'hC1);
        model_req(2, 1'b0, 1'b1, 16'h0041, 8'hD2);
        check("overrun_clear", ovr[2], 0);
        ndone = 0;
        rd[2] = 1'b1; addr[2] = 16'h0040;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rd[2]   = (k == 2);
            addr[2] = (k == 2) ? 16'h0041 : 16'h0000;
            if (done[2]) begin
                ndone++;
                check("ovr_done_cycle", k, 4);
                check("ovr_rdata", rdata[2], 8'hC1);
            end
        end
        check("ovr_done_count", ndone, 1);
        check("ovr_sticky", ovr[2], 1);
        model_apply(2, 1'b1, 1'b0, 16'h0040, 8'h00, ee, er);

        // Reset one cycle before the commit of a write: write dropped, no done.
        model_req(0, 1'b0, 1'b1, 16'h0005, 8'h12);
        model_req(0, 1'b1, 1'b0, 16'h0005, 8'h00);
        wr[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 8'h77;
        @(negedge clk);
        wr[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("mid_rst_rdata", rdata[0], 8'h00);
        check("mid_rst_done", done[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_err", err[0], 0);
        check("mid_rst_overrun", ovr[0], 0);
        @(negedge clk);
        rst[0] = 1'b0;
        mdl_rdata[0] = 8'h00;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        model_req(0, 1'b1, 1'b0, 16'h0005, 8'h00);

        // Randomized traffic against the model, after filling every byte.
        for (int d = 0; d < NDUT; d++) begin
            for (int a = 0; a < 256; a++) begin
                ra = 16'($urandom);
                model_req(d, 1'b0, 1'b1, {ra[15:8], 8'(a)}, ra[7:0]);
            end
            for (int n = 0; n < 150; n++) begin
                ra  = 16'($urandom);
                sel = $urandom_range(0, 9);
                model_req(d, (sel == 0) || (sel >= 5), (sel <= 4), ra, 8'($urandom));
            end
        end

        check("final_overrun_ws2", ovr[0], 0);
        check("final_overrun_ws0", ovr[1], 0);
        check("final_overrun_ws3", ovr[2], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
